// File: rtl/down_counter_pkg.sv
// down_counter_pkg: FSM state encoding and digit clamp shared by the down-counter files
package down_counter_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, EXPIRED = 2'd2} state_t;
  function automatic int clamp_digit(input int d, input int modulus);
    return d >= modulus ? modulus - 1 : d;
  endfunction
endpackage

// File: rtl/down_counter_digit.sv
// down_digit: one wrapping down-count digit with parallel load and zero flag
module down_digit #(
  parameter int WIDTH   = 4,
  parameter int MODULUS = 16
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             dec,
  input  logic             ld,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q,
  output logic             zero
);
  localparam logic [WIDTH-1:0] TOP = WIDTH'(MODULUS - 1);
  assign zero = q == '0;
  always_ff @(posedge clk or posedge clr)
    if (clr) q <= '0;
    else if (ld) q <= d_i;
    else if (dec) q <= zero ? TOP : q - 1'b1;
endmodule

// File: rtl/down_counter.sv
// down_counter: cascadable loadable down-counter/timer with borrow out, done pulse and auto-reload
module down_counter
  import down_counter_pkg::*;
#(
  parameter int WIDTH   = 4,
  parameter int MODULUS = 16,
  parameter int DIGITS  = 2
) (
  input  logic                    clk,
  input  logic                    clr,
  input  logic                    ce,
  input  logic                    load,
  input  logic [DIGITS*WIDTH-1:0] data_i,
  input  logic                    reload,
  output logic [DIGITS*WIDTH-1:0] data_o,
  output logic                    bout,
  output logic                    done
);
  state_t state, state_nxt;
  logic [DIGITS*WIDTH-1:0] ld_vec, rl_q, d_vec;
  logic [DIGITS:0] low_zero;
  logic [DIGITS-1:0] zero;
  logic all_zero, term, count_en, reload_now, done_nxt, dig_ld;
  assign low_zero[0] = 1'b1;
  assign all_zero = low_zero[DIGITS];
  assign term = ce & all_zero;
  assign dig_ld = load | reload_now;
  assign d_vec = load ? ld_vec : rl_q;
  for (genvar k = 0; k < DIGITS; k++) begin : g_digit
    assign ld_vec[k*WIDTH +: WIDTH] = WIDTH'(clamp_digit(int'(data_i[k*WIDTH +: WIDTH]), MODULUS));
    assign low_zero[k+1] = low_zero[k] & zero[k];
    down_digit #(.WIDTH(WIDTH), .MODULUS(MODULUS)) u_digit (
      .clk  (clk),
      .clr  (clr),
      .dec  (count_en & low_zero[k]),
      .ld   (dig_ld),
      .d_i  (d_vec[k*WIDTH +: WIDTH]),
      .q    (data_o[k*WIDTH +: WIDTH]),
      .zero (zero[k])
    );
  end
  // terminal count in RUN either reloads or parks at zero; IDLE simply wraps
  always_comb begin
    state_nxt  = load ? RUN : (state == RUN && term && !reload) ? EXPIRED : state;
    count_en   = ce & ((state == IDLE) | ((state == RUN) & ~all_zero));
    reload_now = ~load & (state == RUN) & term & reload;
    done_nxt   = ~load & (state == RUN) & term;
    bout       = ~clr & term & (state != EXPIRED);
  end
  always_ff @(posedge clk or posedge clr)
    if (clr) begin
      state <= IDLE;
      rl_q  <= '0;
      done  <= 1'b0;
    end else begin
      state <= state_nxt;
      done  <= done_nxt;
      if (load) rl_q <= ld_vec;
    end
endmodule

// File: tb/tb_down_counter.sv
// tb_down_counter: directed and random checks of down_counter against an integer-valued timer model
module tb_down_counter;
  logic clk = 1'b0, clr = 1'b1, ce = 1'b0, load = 1'b0, reload = 1'b0;
  logic [7:0] data_i = '0, data_o;
  logic bout, done;
  logic clr_c = 1'b1, ce_c = 1'b0;
  logic [3:0] qa, qb;
  logic bout_a, bout_b, done_a, done_b;
  int total = 0, fails = 0;
  int m_val, m_st, m_rl, m_done, m_bout, va, vb;

  always #5 clk = ~clk;

  down_counter #(.WIDTH(4), .MODULUS(10), .DIGITS(2)) dut (
    .clk(clk), .clr(clr), .ce(ce), .load(load), .data_i(data_i), .reload(reload),
    .data_o(data_o), .bout(bout), .done(done));
  down_counter #(.WIDTH(4), .MODULUS(16), .DIGITS(1)) dut_a (
    .clk(clk), .clr(clr_c), .ce(ce_c), .load(1'b0), .data_i(4'h0), .reload(1'b0),
    .data_o(qa), .bout(bout_a), .done(done_a));
  down_counter #(.WIDTH(4), .MODULUS(16), .DIGITS(1)) dut_b (
    .clk(clk), .clr(clr_c), .ce(bout_a), .load(1'b0), .data_i(4'h0), .reload(1'b0),
    .data_o(qb), .bout(bout_b), .done(done_b));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] to_bcd(input int v);
    return {4'(v / 10), 4'(v % 10)};
  endfunction

  function automatic int clamp_val(input logic [7:0] d);
    int hi, lo;
    hi = d[7:4] > 4'd9 ? 9 : int'(d[7:4]);
    lo = d[3:0] > 4'd9 ? 9 : int'(d[3:0]);
    return hi * 10 + lo;
  endfunction

  // one clock: drive at edge+1, check bout at edge+4, check state at next edge+1
  task automatic step(input logic c_r, input logic c, input logic l, input logic [7:0] d, input logic r);
    clr = c_r; ce = c; load = l; data_i = d; reload = r;
    m_bout = (!c_r && c && m_val == 0 && m_st != 2) ? 1 : 0;
    #3;
    chk("bout", 32'(bout), 32'(m_bout));
    @(posedge clk);
    #1;
    if (c_r) begin
      m_val = 0; m_st = 0; m_rl = 0; m_done = 0;
    end else if (l) begin
      m_val = clamp_val(d); m_rl = m_val; m_st = 1; m_done = 0;
    end else begin
      m_done = 0;
      if (c && m_st == 0) m_val = m_val == 0 ? 99 : m_val - 1;
      else if (c && m_st == 1) begin
        if (m_val != 0) m_val = m_val - 1;
        else begin
          m_done = 1;
          if (r) m_val = m_rl;
          else m_st = 2;
        end
      end
    end
    chk("data_o", 32'(data_o), 32'(to_bcd(m_val)));
    chk("done", 32'(done), 32'(m_done));
  endtask

  initial begin
    m_val = 0; m_st = 0; m_rl = 0; m_done = 0;
    @(posedge clk);
    #1;
    // held clear with ce toggling
    for (int i = 0; i < 4; i++) step(1'b1, 1'(i % 2), 1'b0, 8'h00, 1'b0);
    for (int i = 0; i < 6; i++) step(1'b0, 1'b1, 1'b0, 8'h00, 1'b0);
    // one-shot from 12
    step(1'b0, 1'b1, 1'b1, 8'h12, 1'b0);
    for (int i = 0; i < 15; i++) step(1'b0, 1'b1, 1'b0, 8'h00, 1'b0);
    // auto-reload from 03 with a stall
    step(1'b0, 1'b1, 1'b1, 8'h03, 1'b1);
    for (int i = 0; i < 6; i++) step(1'b0, 1'b1, 1'b0, 8'h00, 1'b1);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
    for (int i = 0; i < 6; i++) step(1'b0, 1'b1, 1'b0, 8'h00, 1'b1);
    // load beats ce, and clamping
    step(1'b0, 1'b1, 1'b1, 8'h05, 1'b0);
    step(1'b0, 1'b1, 1'b1, 8'h07, 1'b0);
    chk("load_no_dec", 32'(data_o), 32'h07);
    step(1'b0, 1'b0, 1'b1, 8'h3F, 1'b0);
    chk("clamp", 32'(data_o), 32'h39);
    // asynchronous clear mid-cycle in RUN
    step(1'b0, 1'b1, 1'b1, 8'h06, 1'b1);
    ce = 1'b1; load = 1'b0;
    #2 clr = 1'b1;
    #1;
    chk("async_clr_data", 32'(data_o), 32'h00);
    chk("async_clr_bout", 32'(bout), 32'h0);
    chk("async_clr_done", 32'(done), 32'h0);
    clr = 1'b0; ce = 1'b0;
    m_val = 0; m_st = 0; m_rl = 0; m_done = 0;
    @(posedge clk);
    #1;
    step(1'b0, 1'b1, 1'b0, 8'h00, 1'b0);
    chk("wrap_after_clr", 32'(data_o), 32'h99);
    // randomized traffic
    for (int i = 0; i < 400; i++)
      step(1'($urandom_range(0, 40) == 0), 1'($urandom_range(0, 3) != 0),
           1'($urandom_range(0, 11) == 0), 8'($urandom), 1'($urandom_range(0, 2) != 0));
    // two single-digit hex stages chained through bout
    clr_c = 1'b0; ce_c = 1'b1;
    va = 0; vb = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1;
      if (va == 0) vb = vb == 0 ? 15 : vb - 1;
      va = va == 0 ? 15 : va - 1;
      chk("chain", 32'({qb, qa}), 32'({4'(vb), 4'(va)}));
    end
    $display("%0d/%0d checks passed", total - fails, total);
    $finish;
  end
endmodule
